// File: rtl/modexp_stream_master_pkg.sv
// Shared definitions for the modexp stream initiator: FSM encoding,
// pending-mask bit positions and default sizing.
package modexp_stream_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_RES = 2'd2,
    ST_RESP     = 2'd3
  } state_e;

  localparam int unsigned CH_BASE    = 0;
  localparam int unsigned CH_POWER   = 1;
  localparam int unsigned CH_MODULUS = 2;

  localparam int unsigned DEFAULT_SIZE           = 64;
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 4096;
  localparam int unsigned DEFAULT_CNT_W          = 16;

endpackage

// File: rtl/modexp_stream_master_hold.sv
// Single-entry master-side stream register: loads a beat, holds tvalid and
// tdata stable until the consumer's tready is sampled high.
module stream_hold_reg #(
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] tdata,
  output logic              tvalid,
  input  logic              tready
);

  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (load) begin
      data_d  = load_data;
      valid_d = 1'b1;
    end else if (valid_q && tready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign tdata  = data_q;
  assign tvalid = valid_q;

endmodule

// File: rtl/modexp_stream_master.sv
// Initiator for the modexp core: takes one job, issues base/power/modulus
// beats independently, collects the result and returns it with error status.
module modexp_stream_master
  import modexp_stream_master_pkg::*;
#(
  parameter int unsigned SIZE           = DEFAULT_SIZE,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int unsigned CNT_W          = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SIZE-1:0]  cmd_base,
  input  logic [SIZE-1:0]  cmd_power,
  input  logic [SIZE-1:0]  cmd_modulus,
  input  logic             cmd_tvalid,
  output logic             cmd_tready,
  output logic [SIZE-1:0]  m_base_tdata,
  output logic             m_base_tvalid,
  input  logic             m_base_tready,
  output logic [SIZE-1:0]  m_power_tdata,
  output logic             m_power_tvalid,
  input  logic             m_power_tready,
  output logic [SIZE-1:0]  m_modulus_tdata,
  output logic             m_modulus_tvalid,
  input  logic             m_modulus_tready,
  input  logic [SIZE-1:0]  s_result_tdata,
  input  logic             s_result_tvalid,
  output logic             s_result_tready,
  output logic [SIZE-1:0]  resp_tdata,
  output logic             resp_error,
  output logic             resp_tvalid,
  input  logic             resp_tready,
  output logic [CNT_W-1:0] jobs_done
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  state_e            state_q, state_d;
  logic [2:0]        pending_q, pending_d;
  logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic [SIZE-1:0]   resp_data_q, resp_data_d;
  logic              resp_error_q, resp_error_d;
  logic [CNT_W-1:0]  jobs_done_q, jobs_done_d;
  logic              load;
  logic [2:0]        hs_vec;

  assign hs_vec[CH_BASE]    = m_base_tvalid    & m_base_tready;
  assign hs_vec[CH_POWER]   = m_power_tvalid   & m_power_tready;
  assign hs_vec[CH_MODULUS] = m_modulus_tvalid & m_modulus_tready;

  stream_hold_reg #(.DATA_W(SIZE)) u_base (
    .clk(clk), .rst(rst), .load(load), .load_data(cmd_base),
    .tdata(m_base_tdata), .tvalid(m_base_tvalid), .tready(m_base_tready)
  );

  stream_hold_reg #(.DATA_W(SIZE)) u_power (
    .clk(clk), .rst(rst), .load(load), .load_data(cmd_power),
    .tdata(m_power_tdata), .tvalid(m_power_tvalid), .tready(m_power_tready)
  );

  stream_hold_reg #(.DATA_W(SIZE)) u_modulus (
    .clk(clk), .rst(rst), .load(load), .load_data(cmd_modulus),
    .tdata(m_modulus_tdata), .tvalid(m_modulus_tvalid), .tready(m_modulus_tready)
  );

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    tmo_cnt_d    = tmo_cnt_q;
    resp_data_d  = resp_data_q;
    resp_error_d = resp_error_q;
    jobs_done_d  = jobs_done_q;
    load         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_tvalid) begin
          // Modulus 0 or 1 has no meaningful result; answer without touching the core.
          if (cmd_modulus <= SIZE'(1)) begin
            resp_data_d  = '0;
            resp_error_d = 1'b1;
            state_d      = ST_RESP;
          end else begin
            load      = 1'b1;
            pending_d = 3'b111;
            state_d   = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        pending_d = pending_q & ~hs_vec;
        if (pending_d == 3'b000) begin
          tmo_cnt_d = '0;
          state_d   = ST_WAIT_RES;
        end
      end
      ST_WAIT_RES: begin
        if (s_result_tvalid) begin
          resp_data_d  = s_result_tdata;
          resp_error_d = 1'b0;
          state_d      = ST_RESP;
        end else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          resp_data_d  = '0;
          resp_error_d = 1'b1;
          state_d      = ST_RESP;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end
      ST_RESP: begin
        if (resp_tready) begin
          if (!resp_error_q) jobs_done_d = jobs_done_q + CNT_W'(1);
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      pending_q    <= '0;
      tmo_cnt_q    <= '0;
      resp_data_q  <= '0;
      resp_error_q <= 1'b0;
      jobs_done_q  <= '0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      tmo_cnt_q    <= tmo_cnt_d;
      resp_data_q  <= resp_data_d;
      resp_error_q <= resp_error_d;
      jobs_done_q  <= jobs_done_d;
    end
  end

  // Gating with rst keeps the command port closed while reset is held.
  assign cmd_tready      = rst & (state_q == ST_IDLE);
  assign s_result_tready = (state_q == ST_WAIT_RES);
  assign resp_tvalid     = (state_q == ST_RESP);
  assign resp_tdata      = resp_data_q;
  assign resp_error      = resp_error_q;
  assign jobs_done       = jobs_done_q;

endmodule

// File: tb/tb_modexp_stream_master.sv
// Directed bench for modexp_stream_master; the bench plays both the
// command issuer and the modexp core.
module tb_modexp_stream_master;

  localparam int unsigned SIZE  = 64;
  localparam int unsigned TMO   = 16;
  localparam int unsigned CNT_W = 16;

  logic             clk;
  logic             rst;
  logic [SIZE-1:0]  cmd_base, cmd_power, cmd_modulus;
  logic             cmd_tvalid, cmd_tready;
  logic [SIZE-1:0]  m_base_tdata, m_power_tdata, m_modulus_tdata;
  logic             m_base_tvalid, m_power_tvalid, m_modulus_tvalid;
  logic             m_base_tready, m_power_tready, m_modulus_tready;
  logic [SIZE-1:0]  s_result_tdata;
  logic             s_result_tvalid, s_result_tready;
  logic [SIZE-1:0]  resp_tdata;
  logic             resp_error, resp_tvalid, resp_tready;
  logic [CNT_W-1:0] jobs_done;

  int checks = 0;
  int errors = 0;
  int base_beats = 0, power_beats = 0, mod_beats = 0;

  modexp_stream_master #(.SIZE(SIZE), .TIMEOUT_CYCLES(TMO), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_base(cmd_base), .cmd_power(cmd_power), .cmd_modulus(cmd_modulus),
    .cmd_tvalid(cmd_tvalid), .cmd_tready(cmd_tready),
    .m_base_tdata(m_base_tdata), .m_base_tvalid(m_base_tvalid), .m_base_tready(m_base_tready),
    .m_power_tdata(m_power_tdata), .m_power_tvalid(m_power_tvalid), .m_power_tready(m_power_tready),
    .m_modulus_tdata(m_modulus_tdata), .m_modulus_tvalid(m_modulus_tvalid),
    .m_modulus_tready(m_modulus_tready),
    .s_result_tdata(s_result_tdata), .s_result_tvalid(s_result_tvalid),
    .s_result_tready(s_result_tready),
    .resp_tdata(resp_tdata), .resp_error(resp_error), .resp_tvalid(resp_tvalid),
    .resp_tready(resp_tready), .jobs_done(jobs_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (m_base_tvalid && m_base_tready) base_beats++;
    if (m_power_tvalid && m_power_tready) power_beats++;
    if (m_modulus_tvalid && m_modulus_tready) mod_beats++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [SIZE-1:0] modexp(input logic [SIZE-1:0] b, p, m);
    logic [127:0] r, x;
    r = 128'(1) % 128'(m);
    x = 128'(b) % 128'(m);
    for (int i = 0; i < SIZE; i++) begin
      if (p[i]) r = (r * x) % 128'(m);
      x = (x * x) % 128'(m);
    end
    return r[SIZE-1:0];
  endfunction

  task automatic clear_beats();
    base_beats = 0; power_beats = 0; mod_beats = 0;
  endtask

  task automatic drive_cmd(input logic [SIZE-1:0] b, p, m);
    cmd_base = b; cmd_power = p; cmd_modulus = m; cmd_tvalid = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (cmd_tready !== 1'b0) begin errors++; $display("FAIL reset_cmd_tready got %b want 0", cmd_tready); end
    checks++; if ({m_base_tvalid, m_power_tvalid, m_modulus_tvalid, s_result_tready, resp_tvalid} !== 5'b0) begin
      errors++; $display("FAIL reset_valids got %b want 00000",
        {m_base_tvalid, m_power_tvalid, m_modulus_tvalid, s_result_tready, resp_tvalid}); end
    checks++; if ({jobs_done, resp_error, resp_tdata} !== '0) begin
      errors++; $display("FAIL reset_regs jobs=%0d err=%b data=%0h want 0", jobs_done, resp_error, resp_tdata); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (cmd_tready !== 1'b1) begin errors++; $display("FAIL idle_cmd_tready got %b want 1", cmd_tready); end
  endtask

  task automatic test_nominal();
    logic [SIZE-1:0] b, p, m, expv;
    b = 64'd1435631627; p = 64'd21376213; m = 64'd69814;
    expv = modexp(b, p, m);
    clear_beats();
    m_base_tready = 1; m_power_tready = 1; m_modulus_tready = 1; resp_tready = 0;
    drive_cmd(b, p, m);
    checks++; if (cmd_tready !== 1'b1) begin errors++; $display("FAIL nom_cmd_tready got %b want 1", cmd_tready); end
    @(negedge clk);
    cmd_tvalid = 0;
    checks++; if ({m_base_tvalid, m_power_tvalid, m_modulus_tvalid} !== 3'b111) begin
      errors++; $display("FAIL nom_issue_valids got %b want 111", {m_base_tvalid, m_power_tvalid, m_modulus_tvalid}); end
    checks++; if ({m_base_tdata, m_power_tdata, m_modulus_tdata} !== {b, p, m}) begin
      errors++; $display("FAIL nom_issue_data got %0d/%0d/%0d want %0d/%0d/%0d",
        m_base_tdata, m_power_tdata, m_modulus_tdata, b, p, m); end
    @(negedge clk);
    checks++; if ({m_base_tvalid, m_power_tvalid, m_modulus_tvalid, s_result_tready} !== 4'b0001) begin
      errors++; $display("FAIL nom_wait_entry got %b want 0001",
        {m_base_tvalid, m_power_tvalid, m_modulus_tvalid, s_result_tready}); end
    s_result_tdata = expv; s_result_tvalid = 1;
    @(negedge clk);
    s_result_tvalid = 0;
    checks++; if ({resp_tvalid, resp_error, resp_tdata} !== {2'b10, expv}) begin
      errors++; $display("FAIL nom_resp got v=%b e=%b d=%0d want v=1 e=0 d=%0d", resp_tvalid, resp_error, resp_tdata, expv); end
    resp_tready = 1;
    @(negedge clk);
    resp_tready = 0;
    checks++; if (jobs_done !== 16'd1) begin errors++; $display("FAIL nom_jobs got %0d want 1", jobs_done); end
    checks++; if ({base_beats, power_beats, mod_beats} !== {32'd1, 32'd1, 32'd1}) begin
      errors++; $display("FAIL nom_beats got %0d/%0d/%0d want 1/1/1", base_beats, power_beats, mod_beats); end
  endtask

  task automatic test_staggered();
    logic [SIZE-1:0] b, p, m;
    b = 64'd4; p = 64'd13; m = 64'd497;
    clear_beats();
    m_base_tready = 1; m_power_tready = 0; m_modulus_tready = 0;
    drive_cmd(b, p, m);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      cmd_tvalid = 0;
      m_power_tready = (c >= 6);
      m_modulus_tready = (c >= 10);
      checks++; if ({m_base_tvalid, m_power_tvalid, m_modulus_tvalid} !== {c == 1, c <= 6, c <= 10}) begin
        errors++; $display("FAIL stag_valids cycle %0d got %b want %b", c,
          {m_base_tvalid, m_power_tvalid, m_modulus_tvalid}, {c == 1, c <= 6, c <= 10}); end
      checks++; if ({m_power_tdata, m_modulus_tdata, s_result_tready} !== {p, m, 1'b0}) begin
        errors++; $display("FAIL stag_hold cycle %0d got p=%0d m=%0d rdy=%b want p=%0d m=%0d rdy=0", c,
          m_power_tdata, m_modulus_tdata, s_result_tready, p, m); end
    end
    @(negedge clk);
    m_power_tready = 0; m_modulus_tready = 0;
    checks++; if (s_result_tready !== 1'b1) begin errors++; $display("FAIL stag_wait_entry got %b want 1", s_result_tready); end
    s_result_tdata = modexp(b, p, m); s_result_tvalid = 1;
    @(negedge clk);
    s_result_tvalid = 0;
    checks++; if (resp_tdata !== 64'd445) begin errors++; $display("FAIL stag_resp got %0d want 445", resp_tdata); end
    resp_tready = 1;
    @(negedge clk);
    resp_tready = 0;
    checks++; if ({base_beats, power_beats, mod_beats} !== {32'd1, 32'd1, 32'd1}) begin
      errors++; $display("FAIL stag_beats got %0d/%0d/%0d want 1/1/1", base_beats, power_beats, mod_beats); end
    checks++; if (jobs_done !== 16'd2) begin errors++; $display("FAIL stag_jobs got %0d want 2", jobs_done); end
  endtask

  task automatic test_invalid_modulus();
    for (int k = 0; k < 2; k++) begin
      clear_beats();
      m_base_tready = 1; m_power_tready = 1; m_modulus_tready = 1;
      drive_cmd(64'd123, 64'd45, 64'(k));
      @(negedge clk);
      cmd_tvalid = 0;
      checks++; if ({resp_tvalid, resp_error, resp_tdata} !== {2'b11, 64'd0}) begin
        errors++; $display("FAIL inv_resp mod=%0d got v=%b e=%b d=%0d want v=1 e=1 d=0", k, resp_tvalid, resp_error, resp_tdata); end
      checks++; if ({m_base_tvalid, m_power_tvalid, m_modulus_tvalid} !== 3'b000) begin
        errors++; $display("FAIL inv_no_issue mod=%0d got %b want 000", k, {m_base_tvalid, m_power_tvalid, m_modulus_tvalid}); end
      resp_tready = 1;
      @(negedge clk);
      resp_tready = 0;
      checks++; if ({jobs_done, cmd_tready} !== {16'd2, 1'b1}) begin
        errors++; $display("FAIL inv_after mod=%0d got jobs=%0d rdy=%b want jobs=2 rdy=1", k, jobs_done, cmd_tready); end
      checks++; if (base_beats + power_beats + mod_beats !== 0) begin
        errors++; $display("FAIL inv_beats mod=%0d got %0d want 0", k, base_beats + power_beats + mod_beats); end
    end
  endtask

  task automatic test_timeout();
    m_base_tready = 1; m_power_tready = 1; m_modulus_tready = 1;
    drive_cmd(64'd7, 64'd3, 64'd11);
    @(negedge clk);
    cmd_tvalid = 0;
    @(negedge clk);
    checks++; if (s_result_tready !== 1'b1) begin errors++; $display("FAIL tmo_entry got %b want 1", s_result_tready); end
    for (int c = 3; c <= 17; c++) @(negedge clk);
    checks++; if ({resp_tvalid, s_result_tready} !== 2'b01) begin
      errors++; $display("FAIL tmo_early got v=%b rdy=%b want v=0 rdy=1", resp_tvalid, s_result_tready); end
    @(negedge clk);
    checks++; if ({resp_tvalid, resp_error, resp_tdata} !== {2'b11, 64'd0}) begin
      errors++; $display("FAIL tmo_resp got v=%b e=%b d=%0d want v=1 e=1 d=0", resp_tvalid, resp_error, resp_tdata); end
    s_result_tdata = 64'hABCD; s_result_tvalid = 1;
    @(negedge clk);
    checks++; if ({s_result_tready, resp_tvalid, resp_tdata} !== {2'b01, 64'd0}) begin
      errors++; $display("FAIL tmo_late got rdy=%b v=%b d=%0h want rdy=0 v=1 d=0", s_result_tready, resp_tvalid, resp_tdata); end
    resp_tready = 1;
    @(negedge clk);
    resp_tready = 0; s_result_tvalid = 0;
    checks++; if ({jobs_done, cmd_tready} !== {16'd2, 1'b1}) begin
      errors++; $display("FAIL tmo_after got jobs=%0d rdy=%b want jobs=2 rdy=1", jobs_done, cmd_tready); end
  endtask

  task automatic test_back_to_back();
    logic [SIZE-1:0] exp1;
    exp1 = modexp(64'd5, 64'd117, 64'd19);
    m_base_tready = 1; m_power_tready = 1; m_modulus_tready = 1;
    drive_cmd(64'd5, 64'd117, 64'd19);
    @(negedge clk);
    cmd_tvalid = 0;
    @(negedge clk);
    s_result_tdata = exp1; s_result_tvalid = 1;
    @(negedge clk);
    s_result_tvalid = 0;
    drive_cmd(64'd4, 64'd13, 64'd497);
    for (int k = 0; k < 7; k++) begin
      checks++; if ({resp_tvalid, cmd_tready, resp_tdata} !== {2'b10, exp1}) begin
        errors++; $display("FAIL bp_hold cycle %0d got v=%b crdy=%b d=%0d want v=1 crdy=0 d=%0d", k,
          resp_tvalid, cmd_tready, resp_tdata, exp1); end
      @(negedge clk);
    end
    resp_tready = 1;
    @(negedge clk);
    resp_tready = 0;
    checks++; if ({cmd_tready, jobs_done} !== {1'b1, 16'd3}) begin
      errors++; $display("FAIL bp_next_accept got crdy=%b jobs=%0d want crdy=1 jobs=3", cmd_tready, jobs_done); end
    @(negedge clk);
    cmd_tvalid = 0;
    checks++; if ({m_base_tvalid, m_base_tdata} !== {1'b1, 64'd4}) begin
      errors++; $display("FAIL bp_issue got v=%b d=%0d want v=1 d=4", m_base_tvalid, m_base_tdata); end
    @(negedge clk);
    s_result_tdata = modexp(64'd4, 64'd13, 64'd497); s_result_tvalid = 1;
    @(negedge clk);
    s_result_tvalid = 0;
    checks++; if ({resp_tvalid, resp_tdata} !== {1'b1, 64'd445}) begin
      errors++; $display("FAIL bp_second_resp got v=%b d=%0d want v=1 d=445", resp_tvalid, resp_tdata); end
    resp_tready = 1;
    @(negedge clk);
    resp_tready = 0;
    checks++; if (jobs_done !== 16'd4) begin errors++; $display("FAIL bp_jobs got %0d want 4", jobs_done); end
  endtask

  task automatic test_reset_mid_issue();
    m_base_tready = 0; m_power_tready = 0; m_modulus_tready = 0;
    drive_cmd(64'd9, 64'd5, 64'd13);
    @(negedge clk);
    cmd_tvalid = 0;
    checks++; if (m_base_tvalid !== 1'b1) begin errors++; $display("FAIL rmi_pre got %b want 1", m_base_tvalid); end
    #2 rst = 1'b0;
    #1;
    checks++; if ({m_base_tvalid, m_power_tvalid, m_modulus_tvalid, cmd_tready} !== 4'b0000) begin
      errors++; $display("FAIL rmi_async got %b want 0000", {m_base_tvalid, m_power_tvalid, m_modulus_tvalid, cmd_tready}); end
    checks++; if (jobs_done !== 16'd0) begin errors++; $display("FAIL rmi_jobs got %0d want 0", jobs_done); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (cmd_tready !== 1'b1) begin errors++; $display("FAIL rmi_idle got %b want 1", cmd_tready); end
    m_base_tready = 1; m_power_tready = 1; m_modulus_tready = 1;
    drive_cmd(64'd9, 64'd5, 64'd13);
    @(negedge clk);
    cmd_tvalid = 0;
    @(negedge clk);
    s_result_tdata = modexp(64'd9, 64'd5, 64'd13); s_result_tvalid = 1;
    @(negedge clk);
    s_result_tvalid = 0;
    checks++; if ({resp_tvalid, resp_error, resp_tdata} !== {2'b10, 64'd3}) begin
      errors++; $display("FAIL rmi_resp got v=%b e=%b d=%0d want v=1 e=0 d=3", resp_tvalid, resp_error, resp_tdata); end
    resp_tready = 1;
    @(negedge clk);
    resp_tready = 0;
    checks++; if (jobs_done !== 16'd1) begin errors++; $display("FAIL rmi_jobs_after got %0d want 1", jobs_done); end
  endtask

  initial begin
    rst = 1'b1;
    cmd_base = '0; cmd_power = '0; cmd_modulus = '0; cmd_tvalid = 0;
    m_base_tready = 0; m_power_tready = 0; m_modulus_tready = 0;
    s_result_tdata = '0; s_result_tvalid = 0; resp_tready = 0;
    #2 rst = 1'b0;
    test_reset();
    test_nominal();
    test_staggered();
    test_invalid_modulus();
    test_timeout();
    test_back_to_back();
    test_reset_mid_issue();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
